// File: rtl/ms_period_timer_pkg.sv
// Shared constants for the millisecond timebase and period timer.
// Mode encodings and default clock rates.
package ms_period_timer_pkg;

    localparam logic MODE_PERIODIC  = 1'b0;
    localparam logic MODE_ONESHOT   = 1'b1;
    localparam int   CLK_HZ         = 100_000_000;
    localparam int   CYC_PER_MS_DEF = CLK_HZ / 1000;

endpackage

// File: rtl/ms_period_timer_prescaler.sv
// Terminal-count divider producing a one-cycle tick every CYC_PER_MS run cycles.
// tick is combinational: it is high during the cycle whose edge wraps the counter.
module ms_prescaler
    import ms_period_timer_pkg::*;
#(
    parameter int CYC_PER_MS = CYC_PER_MS_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    input  logic clr,
    output logic tick
);

    localparam int              CW   = $clog2(CYC_PER_MS);
    localparam logic [CW-1:0]   TERM = CW'(CYC_PER_MS - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // A clear on the wrap edge suppresses the tick so a restart never leaks a strobe.
    assign tick = run & ~clr & (cnt_q == TERM);

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (run) begin
            cnt_d = (cnt_q == TERM) ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/ms_period_timer.sv
// Millisecond timebase plus programmable period timer with periodic and one-shot modes.
// All outputs registered; strobes appear one cycle after the prescaler wraps.
module ms_period_timer
    import ms_period_timer_pkg::*;
#(
    parameter int CYC_PER_MS = CYC_PER_MS_DEF,
    parameter int PERIOD_W   = 10
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic                mode,
    input  logic [PERIOD_W-1:0] period_ms,
    input  logic                start,
    input  logic                stop,
    output logic                ms_tick,
    output logic                period_tick,
    output logic [PERIOD_W-1:0] count_ms,
    output logic                busy
);

    localparam logic [PERIOD_W-1:0] ONE = PERIOD_W'(1);

    logic                busy_q, busy_d;
    logic                mode_q, mode_d;
    logic [PERIOD_W-1:0] period_q, period_d;
    logic [PERIOD_W-1:0] count_q, count_d;
    logic                ms_tick_q, ms_tick_d;
    logic                period_tick_q, period_tick_d;
    logic                pre_tick;

    ms_prescaler #(
        .CYC_PER_MS (CYC_PER_MS)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .run  (busy_q & enable),
        .clr  (start | stop),
        .tick (pre_tick)
    );

    always_comb begin
        busy_d        = busy_q;
        mode_d        = mode_q;
        period_d      = period_q;
        count_d       = count_q;
        ms_tick_d     = pre_tick;
        period_tick_d = 1'b0;
        if (stop) begin
            busy_d    = 1'b0;
            count_d   = '0;
            ms_tick_d = 1'b0;
        end else if (start) begin
            busy_d    = 1'b1;
            count_d   = '0;
            mode_d    = mode;
            // A zero period would never terminate; treat it as one millisecond.
            period_d  = (period_ms == '0) ? ONE : period_ms;
            ms_tick_d = 1'b0;
        end else if (pre_tick) begin
            if (count_q == period_q - ONE) begin
                count_d       = '0;
                period_tick_d = 1'b1;
                if (mode_q == MODE_ONESHOT) begin
                    busy_d = 1'b0;
                end
            end else begin
                count_d = count_q + ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_q        <= 1'b0;
            mode_q        <= MODE_PERIODIC;
            period_q      <= '0;
            count_q       <= '0;
            ms_tick_q     <= 1'b0;
            period_tick_q <= 1'b0;
        end else begin
            busy_q        <= busy_d;
            mode_q        <= mode_d;
            period_q      <= period_d;
            count_q       <= count_d;
            ms_tick_q     <= ms_tick_d;
            period_tick_q <= period_tick_d;
        end
    end

    assign ms_tick     = ms_tick_q;
    assign period_tick = period_tick_q;
    assign count_ms    = count_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_ms_period_timer.sv
// Directed, table-driven check of ms_period_timer with CYC_PER_MS=4, PERIOD_W=4.
module tb_ms_period_timer;

    localparam int CYC = 4;
    localparam int PW  = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          enable = 1'b0;
    logic          mode = 1'b0;
    logic [PW-1:0] period_ms = '0;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic          ms_tick, period_tick, busy;
    logic [PW-1:0] count_ms;

    int total = 0;
    int bad   = 0;

    ms_period_timer #(.CYC_PER_MS(CYC), .PERIOD_W(PW)) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .mode        (mode),
        .period_ms   (period_ms),
        .start       (start),
        .stop        (stop),
        .ms_tick     (ms_tick),
        .period_tick (period_tick),
        .count_ms    (count_ms),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          st, sp, en, md;
        logic [PW-1:0] per;
        logic          e_ms, e_pt;
        logic [PW-1:0] e_cnt;
        logic          e_bz;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(input logic st, sp, en, md, input logic [PW-1:0] per,
                                input logic ms, pt, input logic [PW-1:0] cnt, input logic bz);
        vec_t v;
        v.st = st; v.sp = sp; v.en = en; v.md = md; v.per = per;
        v.e_ms = ms; v.e_pt = pt; v.e_cnt = cnt; v.e_bz = bz;
        return v;
    endfunction

    task automatic rep(input int n, input logic st, sp, en, md, input logic [PW-1:0] per,
                       input logic ms, pt, input logic [PW-1:0] cnt, input logic bz);
        for (int k = 0; k < n; k++) vq.push_back(mk(st, sp, en, md, per, ms, pt, cnt, bz));
    endtask

    function automatic logic [6:0] outs();
        return {ms_tick, period_tick, count_ms, busy};
    endfunction

    task automatic check(input string name, input logic [6:0] act, input logic [6:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got {ms,pt,cnt,busy}=%b want %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input logic st, sp, en, md, input logic [PW-1:0] per);
        start = st; stop = sp; enable = en; mode = md; period_ms = per;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n_ms, n_pt, n_dbl;
        logic prev_ms;

        repeat (2) @(posedge clk);
        #1;
        check("reset_hold", outs(), 7'b0);
        rst = 1'b1;

        // idle after reset: no ticks with enable high
        rep(6, 0,0,1,0,3, 0,0,0,0);
        // periodic, period 3; period_ms changed to 7 while busy is ignored
        vq.push_back(mk(1,0,1,0,3, 0,0,0,1));
        rep(3, 0,0,1,0,7, 0,0,0,1);
        vq.push_back(mk(0,0,1,0,7, 1,0,1,1));
        rep(3, 0,0,1,0,7, 0,0,1,1);
        vq.push_back(mk(0,0,1,0,7, 1,0,2,1));
        rep(3, 0,0,1,0,7, 0,0,2,1);
        vq.push_back(mk(0,0,1,0,7, 1,1,0,1));
        vq.push_back(mk(0,1,1,0,7, 0,0,0,0));
        rep(2, 0,0,1,0,7, 0,0,0,0);
        // one-shot, period 2; mode change while busy ignored
        vq.push_back(mk(1,0,1,1,2, 0,0,0,1));
        rep(3, 0,0,1,0,2, 0,0,0,1);
        vq.push_back(mk(0,0,1,0,2, 1,0,1,1));
        rep(3, 0,0,1,0,2, 0,0,1,1);
        vq.push_back(mk(0,0,1,0,2, 1,1,0,0));
        rep(5, 0,0,1,0,2, 0,0,0,0);
        // pause: enable low for 10 clks after clk 2 -> first tick at clk 14
        vq.push_back(mk(1,0,1,0,3, 0,0,0,1));
        rep(2, 0,0,1,0,3, 0,0,0,1);
        rep(10, 0,0,0,0,3, 0,0,0,1);
        vq.push_back(mk(0,0,1,0,3, 0,0,0,1));
        vq.push_back(mk(0,0,1,0,3, 1,0,1,1));
        // restart at clk 6 -> next tick at clk 10
        vq.push_back(mk(1,0,1,0,3, 0,0,0,1));
        rep(3, 0,0,1,0,3, 0,0,0,1);
        vq.push_back(mk(0,0,1,0,3, 1,0,1,1));
        vq.push_back(mk(0,0,1,0,3, 0,0,1,1));
        vq.push_back(mk(1,0,1,0,3, 0,0,0,1));
        rep(3, 0,0,1,0,3, 0,0,0,1);
        vq.push_back(mk(0,0,1,0,3, 1,0,1,1));
        // start and stop together: stop wins
        vq.push_back(mk(1,1,1,0,3, 0,0,0,0));
        rep(5, 0,0,1,0,3, 0,0,0,0);
        // period 0 behaves as 1
        vq.push_back(mk(1,0,1,0,0, 0,0,0,1));
        rep(3, 0,0,1,0,0, 0,0,0,1);
        vq.push_back(mk(0,0,1,0,0, 1,1,0,1));
        rep(3, 0,0,1,0,0, 0,0,0,1);
        vq.push_back(mk(0,0,1,0,0, 1,1,0,1));
        vq.push_back(mk(0,1,1,0,0, 0,0,0,0));

        foreach (vq[i]) begin
            step(vq[i].st, vq[i].sp, vq[i].en, vq[i].md, vq[i].per);
            check($sformatf("vec%0d", i), outs(),
                  {vq[i].e_ms, vq[i].e_pt, vq[i].e_cnt, vq[i].e_bz});
        end

        // reset asserted while ms_tick is high clears everything immediately
        step(1,0,1,0,3);
        repeat (4) step(0,0,1,0,3);
        check("rst_pre_tick", outs(), 7'b1_0_0001_1);
        #2 rst = 1'b0;
        #1 check("rst_async", outs(), 7'b0);
        @(posedge clk);
        #1 rst = 1'b1;
        for (int k = 0; k < 8; k++) begin
            step(0,0,1,0,3);
            check($sformatf("rst_idle%0d", k), outs(), 7'b0);
        end

        // long periodic run: strobe counts and single-cycle width
        step(1,0,1,0,3);
        n_ms = 0; n_pt = 0; n_dbl = 0; prev_ms = 1'b0;
        for (int k = 0; k < 36; k++) begin
            step(0,0,1,0,3);
            if (ms_tick) n_ms++;
            if (period_tick) n_pt++;
            if (ms_tick && prev_ms) n_dbl++;
            prev_ms = ms_tick;
        end
        check("long_ms_count", 7'(n_ms), 7'd9);
        check("long_pt_count", 7'(n_pt), 7'd3);
        check("long_stretch", 7'(n_dbl), 7'd0);
        step(0,1,1,0,3);
        check("long_stop", outs(), 7'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
